// File: rtl/voice_amplifier.sv
// Voice-sample amplifier: two-stage pipeline scaling din by an 8-bit envelope level (255 = exact unity).
// Optional gain slew limiting is compiled in with the macro VOICE_AMPLIFIER_SLEW_EN.
module voice_amplifier #(
    parameter int DATA_BITS = 12,
    parameter int SLEW_DIV  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_BITS-1:0] din,
    input  logic                        din_valid,
    input  logic [7:0]                  amplitude,
    output logic signed [DATA_BITS-1:0] dout,
    output logic                        dout_valid,
    output logic                        idle
);

    localparam int PROD_BITS = DATA_BITS + 9;

    logic [7:0]                  amp_eff_reg;
    logic signed [DATA_BITS-1:0] s1_data_reg;
    logic [7:0]                  s1_amp_reg;
    logic                        s1_valid_reg;
    logic signed [DATA_BITS-1:0] dout_reg;
    logic                        dout_valid_reg;

    logic [8:0]                  gain;
    logic signed [PROD_BITS-1:0] data_ext;
    logic signed [PROD_BITS-1:0] gain_ext;
    logic signed [PROD_BITS-1:0] product;
    logic                        unused_bits;

`ifdef VOICE_AMPLIFIER_SLEW_EN
    localparam logic [15:0] SLEW_LAST = 16'(SLEW_DIV - 1);

    logic [15:0] slew_cnt_reg;

    // Counter runs continuously; the gain moves one LSB only on the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            slew_cnt_reg <= '0;
            amp_eff_reg  <= '0;
        end else if (slew_cnt_reg == SLEW_LAST) begin
            slew_cnt_reg <= '0;
            if (amp_eff_reg < amplitude)
                amp_eff_reg <= amp_eff_reg + 8'd1;
            else if (amp_eff_reg > amplitude)
                amp_eff_reg <= amp_eff_reg - 8'd1;
        end else begin
            slew_cnt_reg <= slew_cnt_reg + 16'd1;
        end
    end
`else
    localparam int unused_slew_div = SLEW_DIV;

    always_ff @(posedge clk) begin
        if (rst)
            amp_eff_reg <= '0;
        else
            amp_eff_reg <= amplitude;
    end
`endif

    // Stage 1 latches the gain in effect before any same-cycle envelope update.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_reg  <= '0;
            s1_amp_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= din_valid;
            if (din_valid) begin
                s1_data_reg <= din;
                s1_amp_reg  <= amp_eff_reg;
            end
        end
    end

    // Full envelope maps to 256 so that 255 gives exact pass-through after the >>8.
    always_comb begin
        gain     = (s1_amp_reg == 8'd255) ? 9'd256 : {1'b0, s1_amp_reg};
        data_ext = {{9{s1_data_reg[DATA_BITS-1]}}, s1_data_reg};
        gain_ext = {{DATA_BITS{1'b0}}, gain};
        product  = data_ext * gain_ext;
    end

    assign unused_bits = ^{product[PROD_BITS-1], product[7:0]};

    // Dropping the low 8 bits of a two's-complement product is a floor shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
                dout_reg <= product[DATA_BITS+7:8];
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign idle       = (amp_eff_reg == 8'd0);

endmodule

// File: tb/tb_voice_amplifier.sv
// Directed bench for voice_amplifier: pipeline latency, gain scaling, floor rounding, reset flush and slew.
module tb_voice_amplifier;

    logic               clk;
    logic               rst;
    logic signed [11:0] din;
    logic               din_valid;
    logic [7:0]         amplitude;
    logic signed [11:0] dout;
    logic               dout_valid;
    logic               idle;

    int checks;
    int failures;

    voice_amplifier #(.DATA_BITS(12), .SLEW_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .amplitude  (amplitude),
        .dout       (dout),
        .dout_valid (dout_valid),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; din = '0; din_valid = 1'b0; amplitude = 8'd0;
        tick(3);
        checks++;
        if (dout !== 12'sd0) begin failures++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", idle); end
        rst = 1'b0;
        tick(1);
        $display("reset: dout=%0d dout_valid=%b idle=%b", dout, dout_valid, idle);
    endtask

`ifndef VOICE_AMPLIFIER_SLEW_EN
    task automatic test_follow;
        amplitude = 8'd77;
        tick(1);
        checks++;
        if (dut.amp_eff_reg !== 8'd77) begin failures++; $display("FAIL follow_amp_eff: got %0d expected 77", dut.amp_eff_reg); end
        $display("follow: amplitude=77 amp_eff=%0d", dut.amp_eff_reg);
    endtask

    task automatic test_unity;
        amplitude = 8'd255;
        tick(2);
        din = -12'sd2048; din_valid = 1'b1;
        tick(1);
        din_valid = 1'b0; din = 12'sd5;
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL unity_early_valid: got %b expected 0", dout_valid); end
        tick(1);
        checks++;
        if (dout_valid !== 1'b1) begin failures++; $display("FAIL unity_valid: got %b expected 1", dout_valid); end
        checks++;
        if (dout !== -12'sd2048) begin failures++; $display("FAIL unity_dout: got %0d expected -2048", dout); end
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL unity_idle: got %b expected 0", idle); end
        tick(1);
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL unity_late_valid: got %b expected 0", dout_valid); end
        checks++;
        if (dout !== -12'sd2048) begin failures++; $display("FAIL unity_hold: got %0d expected -2048", dout); end
        $display("unity: din=-2048 gain=256 dout=%0d", dout);
    endtask

    task automatic test_back_to_back;
        amplitude = 8'd128;
        tick(2);
        din = 12'sd1000; din_valid = 1'b1;
        tick(1);
        din = -12'sd1000;
        tick(1);
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'sd500) begin
            failures++; $display("FAIL b2b_first: got valid=%b dout=%0d expected valid=1 dout=500", dout_valid, dout);
        end
        tick(1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== -12'sd500) begin
            failures++; $display("FAIL b2b_second: got valid=%b dout=%0d expected valid=1 dout=-500", dout_valid, dout);
        end
        tick(1);
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid: got %b expected 0", dout_valid); end
        $display("back_to_back: 1000,-1000 at gain 128 -> last dout=%0d", dout);
    endtask

    task automatic test_zero_and_floor;
        amplitude = 8'd0;
        tick(2);
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL zero_idle: got %b expected 1", idle); end
        din = 12'sd2047; din_valid = 1'b1;
        tick(1);
        din_valid = 1'b0;
        tick(1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'sd0) begin
            failures++; $display("FAIL zero_dout: got valid=%b dout=%0d expected valid=1 dout=0", dout_valid, dout);
        end
        amplitude = 8'd1;
        tick(2);
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL gain1_idle: got %b expected 0", idle); end
        din = -12'sd1; din_valid = 1'b1;
        tick(1);
        din = 12'sd1;
        tick(1);
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== -12'sd1) begin
            failures++; $display("FAIL floor_neg1: got valid=%b dout=%0d expected valid=1 dout=-1", dout_valid, dout);
        end
        tick(1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'sd0) begin
            failures++; $display("FAIL floor_pos1: got valid=%b dout=%0d expected valid=1 dout=0", dout_valid, dout);
        end
        $display("zero_and_floor: idle=%b last dout=%0d", idle, dout);
    endtask

    task automatic test_gain_change;
        amplitude = 8'd64;
        tick(2);
        amplitude = 8'd192; din = 12'sd256; din_valid = 1'b1;
        tick(1);
        tick(1);
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'sd64) begin
            failures++; $display("FAIL gain_change_old: got valid=%b dout=%0d expected valid=1 dout=64", dout_valid, dout);
        end
        tick(1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 12'sd192) begin
            failures++; $display("FAIL gain_change_new: got valid=%b dout=%0d expected valid=1 dout=192", dout_valid, dout);
        end
        tick(1);
        $display("gain_change: 64->192 with din=256 -> dout=%0d", dout);
    endtask
`else
    task automatic test_slew;
        int exp_amp;
        rst = 1'b1; din_valid = 1'b0; amplitude = 8'd3;
        tick(2);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_amp = (k / 4 > 3) ? 3 : k / 4;
            checks++;
            if (dut.amp_eff_reg !== 8'(exp_amp)) begin
                failures++; $display("FAIL slew_step%0d: got %0d expected %0d", k, dut.amp_eff_reg, exp_amp);
            end
        end
        $display("slew: amp_eff settled at %0d", dut.amp_eff_reg);
    endtask
`endif

    task automatic test_reset_mid;
        amplitude = 8'd200;
        tick(2);
        din = 12'sd500; din_valid = 1'b1;
        tick(1);
        rst = 1'b1; din = 12'sd100; din_valid = 1'b1;
        tick(1);
        rst = 1'b0; din_valid = 1'b0;
        checks++;
        if (dout !== 12'sd0 || dout_valid !== 1'b0) begin
            failures++; $display("FAIL flush_reset: got valid=%b dout=%0d expected valid=0 dout=0", dout_valid, dout);
        end
        checks++;
        if (dut.amp_eff_reg !== 8'd0 || idle !== 1'b1) begin
            failures++; $display("FAIL flush_amp: got amp_eff=%0d idle=%b expected 0/1", dut.amp_eff_reg, idle);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (dout_valid !== 1'b0 || dout !== 12'sd0) begin
                failures++; $display("FAIL flush_quiet%0d: got valid=%b dout=%0d expected valid=0 dout=0", i, dout_valid, dout);
            end
        end
        $display("reset_mid: dout=%0d dout_valid=%b", dout, dout_valid);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
`ifndef VOICE_AMPLIFIER_SLEW_EN
        test_follow();
        test_unity();
        test_back_to_back();
        test_zero_and_floor();
        test_gain_change();
`else
        test_slew();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_amplifier.md
VOICE_AMPLIFIER -- requirements
Module: voice_amplifier

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, width of signed voice sample in/out.
REQ-002 SHALL have parameter SLEW_DIV, default 64, clocks per one-LSB gain step when slew is compiled in; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  DATA_BITS  signed voice sample.
REQ-006 SHALL have port din_valid  input  1  din qualifier, one sample per asserted cycle.
REQ-007 SHALL have port amplitude  input  8  unsigned envelope level from the envelope generator.
REQ-008 SHALL have port dout  output  DATA_BITS  signed amplified sample.
REQ-009 SHALL have port dout_valid  output  1  dout qualifier.
REQ-010 SHALL have port idle  output  1  high when the effective gain is 0.

Function
REQ-011 SHALL hold an 8-bit effective-gain register amp_eff, updated every cycle per REQ-025 and REQ-026.
REQ-012 SHALL form a 9-bit gain: 256 when amp_eff = 255, else amp_eff. Full envelope is exact unity.
REQ-013 SHALL capture din and the current amp_eff into stage 1 on a din_valid cycle; an amp_eff update in the same cycle is not used.
REQ-014 SHALL compute in stage 2 the signed product din * gain, DATA_BITS+9 bits wide, then arithmetic shift right 8 (floor) to DATA_BITS bits.
REQ-015 SHALL never overflow, since gain <= 256; no saturation logic.
REQ-016 SHALL assert dout_valid for exactly one cycle, 2 clocks after each din_valid cycle, and update dout in that cycle.
REQ-017 SHALL accept din_valid on consecutive cycles at full throughput, with no backpressure and no sample dropped.
REQ-018 SHALL hold dout at its last value while dout_valid is low.
REQ-019 SHALL drive idle combinationally as (amp_eff == 0).
REQ-020 SHALL produce dout = 0 for any din while gain = 0, and dout = din while gain = 256.
REQ-021 SHALL give, for din = -1 and gain 1..255, dout = -1 (floor rounding); for din = +1 and gain < 256, dout = 0.

Reset
REQ-022 SHALL on rst clear dout to 0, dout_valid to 0, idle-source amp_eff to 0, stage valids to 0, and the slew counter to 0.
REQ-023 SHALL discard samples in flight when rst asserts mid-pipeline; no dout_valid pulse for them after reset.
REQ-024 SHALL ignore din_valid in any cycle where rst is high.

Configuration
REQ-025 SHALL, when macro VOICE_AMPLIFIER_SLEW_EN is undefined, load amp_eff <= amplitude every cycle, so gain follows amplitude with 1 cycle delay.
REQ-026 SHALL, when VOICE_AMPLIFIER_SLEW_EN is defined, run a counter 0..SLEW_DIV-1 that wraps. On the wrap cycle only, amp_eff moves one LSB toward amplitude (+1 if below, -1 if above, hold if equal). No overshoot; 0 and 255 are never crossed.
REQ-027 SHALL keep the slew counter free-running regardless of din_valid and of amplitude equality.

Verification
REQ-028 SHALL test: slew off, amplitude=255, din=-2048 valid at cycle N -> dout=-2048, dout_valid high only at cycle N+2.
REQ-029 SHALL test: slew off, amplitude=128, din=1000, then -1000 on consecutive cycles -> dout=500, then -500 on consecutive cycles.
REQ-030 SHALL test: amplitude=0, din=2047 -> dout=0, idle=1. Then amplitude=1, din=-1 -> dout=-1, idle=0.
REQ-031 SHALL test: slew on, SLEW_DIV=4, amp_eff=0, amplitude steps to 3 -> amp_eff reaches 1, 2, 3 on successive wraps, 4 clocks apart, then holds at 3.
REQ-032 SHALL test: rst asserted the cycle after din_valid -> no dout_valid pulse follows, dout=0, amp_eff=0.
REQ-033 SHALL test: amplitude changes 64->192 in the same cycle as din_valid with din=256 (slew off) -> dout=64, computed from the old gain.
